tmr_err_collector: RTL and testbench

- Downstream consumer of the per-module error sinks (`err_o`) that triplicated sub-modules and voters expose.
- Collects N_SRC error lines in one clock domain into:
  - per-source sticky flags
  - a saturating aggregate event counter
  - first-error source capture
  - a fatal flag raised at a programmable event count.
- Sits at the top level between the error-sink nets and the chip status/IRQ logic. Its own `err_o` is the single aggregated error sink.

---
 rtl/tmr_err_pkg.sv | 29 ++
 rtl/tmr_err_prio_enc.sv | 22 ++
 rtl/tmr_err_collector.sv | 105 ++++++++++
 tb/tb_tmr_err_collector.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tmr_err_pkg.sv
// Shared helpers and defaults for the TMR error-collection logic.
// Provides index-width sizing and a saturating add for error event counters.
package tmr_err_pkg;

  localparam int unsigned ERR_CNT_W_DEF        = 8;
  localparam int unsigned ERR_FATAL_THRESH_DEF = 3;

  // Width needed to index n items, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // cnt + inc, clamped to the largest value representable in w bits.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                          input logic [31:0] inc,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, cnt} + {1'b0, inc};
    max = (33'd1 << w) - 33'd1;
    return 32'((sum > max) ? max : sum);
  endfunction

endpackage

// File: rtl/tmr_err_prio_enc.sv
// Lowest-index priority encoder; purely combinational, no backpressure.
// hit_vld is set when any request bit is set; hit_idx is the lowest set index.
module tmr_err_prio_enc
  import tmr_err_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  output logic          hit_vld,
  output logic [IW-1:0] hit_idx
);

  always_comb begin
    hit_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) hit_idx = IW'(i);
    end
    hit_vld = |req;
  end

endmodule

// File: rtl/tmr_err_collector.sv
// Aggregates error-sink lines into sticky flags, a saturating event count, first-source capture and fatal/irq.
// All outputs registered, one cycle after the triggering rising edge; no backpressure, every edge is recorded.
module tmr_err_collector
  import tmr_err_pkg::*;
#(
  parameter  int unsigned N_SRC        = 4,
  parameter  int unsigned CNT_W        = ERR_CNT_W_DEF,
  parameter  int unsigned FATAL_THRESH = ERR_FATAL_THRESH_DEF,
  localparam int unsigned IDX_W        = idx_w(N_SRC)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SRC-1:0]    err_i,
  input  logic                clr_i,
  input  logic [N_SRC-1:0]    clr_mask_i,
  input  logic                clr_all_i,
  input  logic [N_SRC-1:0]    irq_en_i,
  output logic [N_SRC-1:0]    sticky_o,
  output logic [CNT_W-1:0]    err_cnt_o,
  output logic                first_valid_o,
  output logic [IDX_W-1:0]    first_idx_o,
  output logic                fatal_o,
  output logic                irq_o,
  (* tmrx_error_sink *)
  output logic                err_o
);

  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] events;
  logic [5:0]       pop;
  logic             enc_vld;
  logic [IDX_W-1:0] enc_idx;

  logic [N_SRC-1:0] sticky_n;
  logic [CNT_W-1:0] base_cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             fatal_n;
  logic             first_valid_n;
  logic [IDX_W-1:0] first_idx_n;

  assign events = err_i & ~prev_q;

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      pop = pop + {5'b0, events[i]};
    end
  end

  tmr_err_prio_enc #(
    .N (N_SRC)
  ) u_prio_enc (
    .req     (events),
    .hit_vld (enc_vld),
    .hit_idx (enc_idx)
  );

  // clr_all_i wipes the state first, then this cycle's events are applied on top.
  always_comb begin
    sticky_n      = sticky_o;
    base_cnt      = err_cnt_o;
    fatal_n       = fatal_o;
    first_valid_n = first_valid_o;
    first_idx_n   = first_idx_o;
    if (clr_all_i) begin
      sticky_n      = '0;
      base_cnt      = '0;
      fatal_n       = 1'b0;
      first_valid_n = 1'b0;
      first_idx_n   = '0;
    end else if (clr_i) begin
      sticky_n = sticky_o & ~clr_mask_i;
    end
    sticky_n = sticky_n | events;
    cnt_n    = CNT_W'(sat_add(32'(base_cnt), 32'(pop), CNT_W));
    if (cnt_n >= CNT_W'(FATAL_THRESH)) fatal_n = 1'b1;
    if (!first_valid_n && enc_vld) begin
      first_valid_n = 1'b1;
      first_idx_n   = enc_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q        <= '0;
      sticky_o      <= '0;
      err_cnt_o     <= '0;
      first_valid_o <= 1'b0;
      first_idx_o   <= '0;
      fatal_o       <= 1'b0;
      irq_o         <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      prev_q        <= err_i;
      sticky_o      <= sticky_n;
      err_cnt_o     <= cnt_n;
      first_valid_o <= first_valid_n;
      first_idx_o   <= first_idx_n;
      fatal_o       <= fatal_n;
      irq_o         <= |(sticky_n & irq_en_i);
      err_o         <= |sticky_n;
    end
  end

endmodule

// File: tb/tb_tmr_err_collector.sv
// Randomized + directed bench for tmr_err_collector with a queue-based scoreboard.
// Two instances share stimulus: default counter width and a 2-bit counter for saturation.
module tb_tmr_err_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] err = '0;
  logic       clr = 1'b0;
  logic [3:0] mask = '0;
  logic       clr_all = 1'b0;
  logic [3:0] en = '0;

  logic [3:0] a_sticky, b_sticky;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;
  logic       a_fv, b_fv, a_fat, b_fat, a_irq, b_irq, a_err, b_err;
  logic [1:0] a_fidx, b_fidx;

  always #5 clk = ~clk;

  tmr_err_collector #(.N_SRC(4), .CNT_W(8), .FATAL_THRESH(3)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .err_i(err), .clr_i(clr), .clr_mask_i(mask),
    .clr_all_i(clr_all), .irq_en_i(en), .sticky_o(a_sticky), .err_cnt_o(a_cnt),
    .first_valid_o(a_fv), .first_idx_o(a_fidx), .fatal_o(a_fat), .irq_o(a_irq), .err_o(a_err)
  );

  tmr_err_collector #(.N_SRC(4), .CNT_W(2), .FATAL_THRESH(3)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .err_i(err), .clr_i(clr), .clr_mask_i(mask),
    .clr_all_i(clr_all), .irq_en_i(en), .sticky_o(b_sticky), .err_cnt_o(b_cnt),
    .first_valid_o(b_fv), .first_idx_o(b_fidx), .fatal_o(b_fat), .irq_o(b_irq), .err_o(b_err)
  );

  typedef struct {
    logic [3:0] sticky;
    int         cnt8;
    int         cnt2;
    logic       fv;
    int         fidx;
    logic       fat8;
    logic       fat2;
    logic       irq;
    logic       err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference state, kept as plain integers and bit vectors.
  logic [3:0] m_prev = '0;
  exp_t       m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t zero_state();
    exp_t z;
    z.sticky = '0; z.cnt8 = 0; z.cnt2 = 0; z.fv = 1'b0; z.fidx = 0;
    z.fat8 = 1'b0; z.fat2 = 1'b0; z.irq = 1'b0; z.err = 1'b0;
    return z;
  endfunction

  // Apply one cycle of inputs at the falling edge and predict the state after the next rising edge.
  task automatic drive(input logic r, input logic [3:0] e, input logic c, input logic [3:0] mk,
                       input logic ca, input logic [3:0] ie);
    logic [3:0] ev;
    int n;
    @(negedge clk);
    rst_n = r; err = e; clr = c; mask = mk; clr_all = ca; en = ie;
    if (!r) begin
      m = zero_state();
      m_prev = '0;
    end else begin
      ev = e & ~m_prev;
      m_prev = e;
      n = $countones(ev);
      if (ca) m = zero_state();
      else if (c) m.sticky = m.sticky & ~mk;
      m.sticky = m.sticky | ev;
      m.cnt8 = (m.cnt8 + n > 255) ? 255 : m.cnt8 + n;
      m.cnt2 = (m.cnt2 + n > 3) ? 3 : m.cnt2 + n;
      if (m.cnt8 >= 3) m.fat8 = 1'b1;
      if (m.cnt2 >= 3) m.fat2 = 1'b1;
      if (!m.fv && n > 0) begin
        m.fv = 1'b1;
        for (int k = 3; k >= 0; k--) if (ev[k]) m.fidx = k;
      end
      m.irq = |(m.sticky & ie);
      m.err = |m.sticky;
    end
    q.push_back(m);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, en);
  endtask

  // Monitor: every rising edge presents a new output state; compare it to the oldest prediction.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("sticky",      32'(a_sticky), 32'(x.sticky));
        chk("err_cnt",     32'(a_cnt),    32'(x.cnt8));
        chk("first_valid", 32'(a_fv),     32'(x.fv));
        chk("first_idx",   32'(a_fidx),   32'(x.fidx));
        chk("fatal",       32'(a_fat),    32'(x.fat8));
        chk("irq",         32'(a_irq),    32'(x.irq));
        chk("err_o",       32'(a_err),    32'(x.err));
        chk("sat_sticky",  32'(b_sticky), 32'(x.sticky));
        chk("sat_cnt",     32'(b_cnt),    32'(x.cnt2));
        chk("sat_fv",      32'(b_fv),     32'(x.fv));
        chk("sat_fidx",    32'(b_fidx),   32'(x.fidx));
        chk("sat_fatal",   32'(b_fat),    32'(x.fat2));
        chk("sat_irq",     32'(b_irq),    32'(x.irq));
        chk("sat_err_o",   32'(b_err),    32'(x.err));
      end
    end
  end

  initial begin : stim
    logic [3:0] cur;
    m = zero_state();

    // Reset, then a single pulse on source 2.
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
    drive(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
    idle(2);
    drive(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 4'b1111);
    idle(2);

    // Two simultaneous events from a cleared state, then a third reaching the fatal threshold.
    drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1111);
    drive(1'b1, 4'b1010, 1'b0, 4'b0000, 1'b0, 4'b1111);
    idle(1);
    drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b1111);
    idle(2);

    // A long-held line counts once per rising edge.
    drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000);
    for (int i = 0; i < 10; i++) drive(1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0000);
    drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0000);
    idle(1);

    // Masked clear colliding with a new event on the same bit, with and without its irq enable.
    drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0010);
    drive(1'b1, 4'b0110, 1'b0, 4'b0000, 1'b0, 4'b0010);
    idle(1);
    drive(1'b1, 4'b0010, 1'b1, 4'b0110, 1'b0, 4'b0010);
    idle(1);
    drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0100);
    drive(1'b1, 4'b0110, 1'b0, 4'b0000, 1'b0, 4'b0100);
    idle(1);
    drive(1'b1, 4'b0010, 1'b1, 4'b0110, 1'b0, 4'b0100);
    idle(1);

    // Five separate events saturate the narrow counter, then a full clear.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b1111);
      drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b1111);
    end
    drive(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1111);
    idle(1);
    // Full clear coinciding with new events.
    drive(1'b1, 4'b0110, 1'b0, 4'b0000, 1'b1, 4'b1111);
    idle(1);

    // Line held high across a reset re-counts after release.
    drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b1111);
    drive(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b1111);
    drive(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b1111);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b1111);

    // Random traffic: sparse toggles, occasional clears and resets.
    cur = 4'b0001;
    for (int i = 0; i < 800; i++) begin
      logic [3:0] tg;
      tg = '0;
      for (int k = 0; k < 4; k++) tg[k] = ($urandom_range(0, 3) == 0);
      cur = cur ^ tg;
      drive(($urandom_range(0, 99) != 0), cur,
            ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 39) == 0),
            (($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : en));
    end
    idle(2);

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
